fp_ci_mac: RTL and testbench

//  Multi-cycle custom-instruction FP unit for the n-body force kernel: ADD/SUB/MUL plus multiply-accumulate into NUM_ACC internal fp32 accumulators.

---
 rtl/fp_ci_mac_pkg.sv | 33 +++
 rtl/fp_ci_mac_if.sv | 23 ++
 rtl/fp_ci_mac_lat_counter.sv | 29 ++
 rtl/fp_ci_mac.sv | 204 ++++++++++++++++++++
 tb/tb_fp_ci_mac.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fp_ci_mac_pkg.sv
// Shared types and helpers for the custom-instruction FP MAC unit.
package fp_ci_pkg;

  typedef enum logic [2:0] {
    OP_ADD     = 3'd0,
    OP_SUB     = 3'd1,
    OP_MUL     = 3'd2,
    OP_MAC     = 3'd3,
    OP_ACC_RD  = 3'd4,
    OP_ACC_CLR = 3'd5,
    OP_ACC_LD  = 3'd6,
    OP_RSVD    = 3'd7
  } ci_op_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_WAIT = 2'd1,
    ST_ADD_WAIT = 2'd2,
    ST_FIN      = 2'd3
  } ci_state_e;

  localparam logic [31:0] FP32_ZERO = 32'h0000_0000;

  // Accumulator index width; a single accumulator still gets one (ignored) index bit.
  function automatic int unsigned idx_width(input int unsigned num_acc);
    return (num_acc > 1) ? $clog2(num_acc) : 1;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/fp_ci_mac_if.sv
// CPU custom-instruction handshake between the core and the FP MAC unit.
interface fp_ci_mac_if #(
  parameter int unsigned N_W = 5
);
  logic           clk_en;
  logic           reset_req;
  logic           start;
  logic [N_W-1:0] n;
  logic [31:0]    dataa;
  logic [31:0]    datab;
  logic           done;
  logic [31:0]    result;

  modport master (
    output clk_en, reset_req, start, n, dataa, datab,
    input  done, result
  );

  modport slave (
    input  clk_en, reset_req, start, n, dataa, datab,
    output done, result
  );
endinterface

// File: rtl/fp_ci_mac_lat_counter.sv
// Loadable down-counter timing the external core latencies; advances only on enabled cycles.
module ci_lat_counter #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero_c
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (en) begin
      if (load) begin
        cnt <= load_val;
      end else if (cnt != '0) begin
        cnt <= cnt - W'(1);
      end
    end
  end

  assign zero_c = (cnt == '0);

endmodule

// File: rtl/fp_ci_mac.sv
// Multi-cycle CI FP unit: ADD/SUB/MUL through external cores plus MAC into local fp32 accumulators.
module fp_ci_mac
  import fp_ci_pkg::*;
#(
  parameter int unsigned ADD_LAT = 7,
  parameter int unsigned MUL_LAT = 5,
  parameter int unsigned NUM_ACC = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  fp_ci_mac_if.slave  ci,
  output logic        core_en,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  output logic        add_op,
  input  logic [31:0] add_res,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [31:0] mul_res
);

  localparam int unsigned IDX_W = idx_width(NUM_ACC);
  localparam int unsigned N_W   = 3 + IDX_W;
  localparam int unsigned CNT_W = $clog2(max_u(ADD_LAT, MUL_LAT) + 1);
  localparam logic [IDX_W-1:0] IDX_MASK = IDX_W'(NUM_ACC - 1);

  ci_state_e        state;
  ci_op_e           op_q;
  ci_op_e           op_in_c;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_in_c;
  logic [IDX_W-1:0] rd_idx_c;
  logic [IDX_W-1:0] wr_idx_c;
  logic [31:0]      acc_q [NUM_ACC];
  logic [31:0]      acc_rd_c;
  logic [31:0]      acc_wd_c;
  logic             acc_we_c;
  logic             go_c;
  logic             step_c;
  logic             mac_turn_c;
  logic             mac_wr_c;
  logic             cnt_load_c;
  logic             cnt_zero_c;
  logic [CNT_W-1:0] cnt_val_c;

  assign core_en  = ci.clk_en;
  assign op_in_c  = ci_op_e'(ci.n[2:0]);
  assign idx_in_c = ci.n[N_W-1:3] & IDX_MASK;

  // An enabled, non-aborted cycle is the only one in which anything may advance.
  assign step_c     = ci.clk_en && !ci.reset_req;
  assign go_c       = step_c && (state == ST_IDLE) && ci.start;
  assign mac_turn_c = step_c && (state == ST_MUL_WAIT) && cnt_zero_c && (op_q == OP_MAC);
  assign mac_wr_c   = step_c && (state == ST_ADD_WAIT) && cnt_zero_c && (op_q == OP_MAC);

  // Single read port: the live index while idle (1-cycle ops), the latched one while busy.
  assign rd_idx_c = (state == ST_IDLE) ? idx_in_c : idx_q;
  assign acc_rd_c = acc_q[rd_idx_c];

  // Counter load: the adder latency for ADD/SUB and the MAC second leg, else the multiplier's.
  always_comb begin
    cnt_load_c = 1'b0;
    cnt_val_c  = CNT_W'(MUL_LAT);
    if (mac_turn_c) begin
      cnt_load_c = 1'b1;
      cnt_val_c  = CNT_W'(ADD_LAT);
    end else if (go_c) begin
      case (op_in_c)
        OP_ADD, OP_SUB: begin
          cnt_load_c = 1'b1;
          cnt_val_c  = CNT_W'(ADD_LAT);
        end
        OP_MUL, OP_MAC: begin
          cnt_load_c = 1'b1;
          cnt_val_c  = CNT_W'(MUL_LAT);
        end
        default: cnt_load_c = 1'b0;
      endcase
    end
  end

  ci_lat_counter #(
    .W (CNT_W)
  ) u_lat_counter (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (ci.clk_en),
    .load     (cnt_load_c),
    .load_val (cnt_val_c),
    .zero_c   (cnt_zero_c)
  );

  // Accumulator write port: CLR/LD at start, MAC when the adder result lands.
  always_comb begin
    acc_we_c = 1'b0;
    wr_idx_c = idx_in_c;
    acc_wd_c = FP32_ZERO;
    if (go_c && (op_in_c == OP_ACC_CLR)) begin
      acc_we_c = 1'b1;
    end else if (go_c && (op_in_c == OP_ACC_LD)) begin
      acc_we_c = 1'b1;
      acc_wd_c = ci.dataa;
    end else if (mac_wr_c) begin
      acc_we_c = 1'b1;
      wr_idx_c = idx_q;
      acc_wd_c = add_res;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_ACC; i++) begin
        acc_q[i] <= FP32_ZERO;
      end
    end else if (acc_we_c) begin
      acc_q[wr_idx_c] <= acc_wd_c;
    end
  end

  // Control FSM with registered handshake outputs and core operand ports.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      op_q      <= OP_ADD;
      idx_q     <= '0;
      ci.done   <= 1'b0;
      ci.result <= FP32_ZERO;
      add_a     <= FP32_ZERO;
      add_b     <= FP32_ZERO;
      add_op    <= 1'b0;
      mul_a     <= FP32_ZERO;
      mul_b     <= FP32_ZERO;
    end else if (ci.clk_en) begin
      if (ci.reset_req) begin
        state   <= ST_IDLE;
        ci.done <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            ci.done <= 1'b0;
            if (ci.start) begin
              op_q  <= op_in_c;
              idx_q <= idx_in_c;
              case (op_in_c)
                OP_ADD, OP_SUB: begin
                  add_a  <= ci.dataa;
                  add_b  <= ci.datab;
                  add_op <= (op_in_c == OP_SUB);
                  state  <= ST_ADD_WAIT;
                end
                OP_MUL, OP_MAC: begin
                  mul_a <= ci.dataa;
                  mul_b <= ci.datab;
                  state <= ST_MUL_WAIT;
                end
                OP_ACC_RD: begin
                  ci.result <= acc_rd_c;
                  ci.done   <= 1'b1;
                  state     <= ST_FIN;
                end
                OP_ACC_LD: begin
                  ci.result <= ci.dataa;
                  ci.done   <= 1'b1;
                  state     <= ST_FIN;
                end
                default: begin
                  ci.result <= FP32_ZERO;
                  ci.done   <= 1'b1;
                  state     <= ST_FIN;
                end
              endcase
            end
          end
          ST_MUL_WAIT: begin
            if (cnt_zero_c) begin
              if (op_q == OP_MAC) begin
                add_a  <= mul_res;
                add_b  <= acc_rd_c;
                add_op <= 1'b0;
                state  <= ST_ADD_WAIT;
              end else begin
                ci.result <= mul_res;
                ci.done   <= 1'b1;
                state     <= ST_FIN;
              end
            end
          end
          ST_ADD_WAIT: begin
            if (cnt_zero_c) begin
              ci.result <= add_res;
              ci.done   <= 1'b1;
              state     <= ST_FIN;
            end
          end
          default: begin
            ci.done <= 1'b0;
            state   <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fp_ci_mac.sv
// Scoreboard bench for fp_ci_mac with ideal fixed-latency fp32 adder/multiplier models.
module tb_fp_ci_mac;
  import fp_ci_pkg::*;

  localparam int unsigned ADD_LAT = 7;
  localparam int unsigned MUL_LAT = 5;
  localparam int unsigned NUM_ACC = 4;
  localparam int unsigned N_W     = 5;

  typedef struct {
    logic [31:0] res;
    int unsigned lat;
    int unsigned t0;
    int unsigned r0;
    int unsigned stall;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        core_en, add_op;
  logic [31:0] add_a, add_b, add_res, mul_a, mul_b, mul_res;
  logic [31:0] add_pipe [ADD_LAT];
  logic [31:0] mul_pipe [MUL_LAT];
  logic [31:0] acc_m [NUM_ACC];
  exp_t        sb [$];
  int unsigned ecyc = 0;
  int unsigned rcyc = 0;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  fp_ci_mac_if #(.N_W(N_W)) ci ();

  fp_ci_mac #(
    .ADD_LAT (ADD_LAT),
    .MUL_LAT (MUL_LAT),
    .NUM_ACC (NUM_ACC)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ci      (ci),
    .core_en (core_en),
    .add_a   (add_a),
    .add_b   (add_b),
    .add_op  (add_op),
    .add_res (add_res),
    .mul_a   (mul_a),
    .mul_b   (mul_b),
    .mul_res (mul_res)
  );

  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:0] == 31'd0) return 0.0;
    d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    if (r == 0.0) return 32'h0;
    d = $realtobits(r);
    return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction

  function automatic logic [31:0] rnd_fp();
    int v;
    v = int'($urandom_range(40)) - 20;
    return r2f(real'(v));
  endfunction

  // Ideal cores: fixed-depth pipelines that move only when core_en is high.
  initial begin
    for (int i = 0; i < ADD_LAT; i++) add_pipe[i] = 32'h0;
    for (int i = 0; i < MUL_LAT; i++) mul_pipe[i] = 32'h0;
  end

  always @(posedge clk) begin
    if (core_en) begin
      add_pipe[0] <= r2f(add_op ? f2r(add_a) - f2r(add_b) : f2r(add_a) + f2r(add_b));
      for (int i = 1; i < ADD_LAT; i++) add_pipe[i] <= add_pipe[i-1];
      mul_pipe[0] <= r2f(f2r(mul_a) * f2r(mul_b));
      for (int i = 1; i < MUL_LAT; i++) mul_pipe[i] <= mul_pipe[i-1];
    end
  end

  assign add_res = add_pipe[ADD_LAT-1];
  assign mul_res = mul_pipe[MUL_LAT-1];

  always @(posedge clk) begin
    rcyc <= rcyc + 1;
    if (ci.clk_en) ecyc <= ecyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, expv);
    end
  endtask

  // Every enabled done cycle must match the oldest outstanding expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset_n && ci.clk_en && ci.done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("result", ci.result, e.res);
        check("latency", 32'(ecyc - e.t0), 32'(e.lat));
        check("raw_latency", 32'(rcyc - e.r0), 32'(e.lat + e.stall));
      end
    end
  end

  task automatic issue(input logic [2:0] op, input int idx, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] res, input int unsigned lat,
                       input int unsigned stall, input bit expect_done);
    exp_t e;
    ci.start = 1'b1;
    ci.n     = {2'(idx), op};
    ci.dataa = a;
    ci.datab = b;
    if (expect_done) begin
      e = '{res: res, lat: lat, t0: ecyc, r0: rcyc, stall: stall};
      sb.push_back(e);
    end
    @(negedge clk);
    ci.start = 1'b0;
    ci.n     = 5'($urandom);
    ci.dataa = $urandom;
    ci.datab = $urandom;
  endtask

  task automatic drain(input int unsigned budget);
    int unsigned k = 0;
    while (sb.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("drain_timeout", 32'(sb.size()), 32'd0);
    sb.delete();
    @(negedge clk);
  endtask

  task automatic run(input logic [2:0] op, input int idx, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] res, input int unsigned lat);
    issue(op, idx, a, b, res, lat, 0, 1'b1);
    drain(200);
  endtask

  function automatic int unsigned lat_of(input logic [2:0] op);
    case (op)
      OP_ADD, OP_SUB: return ADD_LAT + 2;
      OP_MUL:         return MUL_LAT + 2;
      OP_MAC:         return MUL_LAT + ADD_LAT + 3;
      default:        return 1;
    endcase
  endfunction

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [2:0]  op;
    logic [31:0] a, b, p, res;
    int          idx;

    ci.clk_en = 1'b1; ci.reset_req = 1'b0; ci.start = 1'b0;
    ci.n = '0; ci.dataa = '0; ci.datab = '0;
    repeat (3) @(negedge clk);
    check("rst_done", 32'(ci.done), 32'd0);
    check("rst_result", ci.result, 32'h0);
    check("rst_add_a", add_a, 32'h0);
    check("rst_add_b", add_b, 32'h0);
    check("rst_add_op", 32'(add_op), 32'd0);
    check("rst_mul_a", mul_a, 32'h0);
    check("rst_mul_b", mul_b, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // 2.5 + 3.0
    run(OP_ADD, 0, 32'h4020_0000, 32'h4040_0000, 32'h40B0_0000, ADD_LAT + 2);

    // Accumulate 2*3 then 1.5*4 into acc 1
    run(OP_ACC_CLR, 1, 32'h1234_5678, 32'h0, 32'h0, 1);
    run(OP_MAC, 1, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, MUL_LAT + ADD_LAT + 3);
    run(OP_MAC, 1, 32'h3FC0_0000, 32'h4080_0000, 32'h4140_0000, MUL_LAT + ADD_LAT + 3);
    run(OP_ACC_RD, 1, 32'h0, 32'h0, 32'h4140_0000, 1);

    // 3.0 * -2.0 with four disabled cycles mid-operation
    issue(OP_MUL, 0, 32'h4040_0000, 32'hC000_0000, 32'hC0C0_0000, MUL_LAT + 2, 4, 1'b1);
    @(negedge clk);
    ci.clk_en = 1'b0;
    repeat (4) begin
      #1 check("core_en_low", 32'(core_en), 32'd0);
      @(negedge clk);
    end
    ci.clk_en = 1'b1;
    #1 check("core_en_high", 32'(core_en), 32'd1);
    drain(200);

    // Starts while busy are ignored; reserved opcode returns 0 and leaves acc alone
    run(OP_ACC_LD, 2, 32'h4049_0FDB, 32'h0, 32'h4049_0FDB, 1);
    issue(OP_MUL, 0, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, MUL_LAT + 2, 0, 1'b1);
    ci.start = 1'b1; ci.n = {2'd2, OP_RSVD};
    @(negedge clk);
    ci.n = {2'd2, OP_ACC_CLR};
    @(negedge clk);
    ci.start = 1'b0;
    drain(200);
    run(OP_RSVD, 2, 32'hFFFF_FFFF, 32'h0, 32'h0, 1);
    run(OP_ACC_RD, 2, 32'h0, 32'h0, 32'h4049_0FDB, 1);

    // reset_req aborts an in-flight MAC without touching its accumulator
    run(OP_ACC_LD, 0, 32'h3F80_0000, 32'h0, 32'h3F80_0000, 1);
    issue(OP_MAC, 0, 32'h4000_0000, 32'h4040_0000, 32'h0, 0, 0, 1'b0);
    repeat (MUL_LAT + 3) @(negedge clk);
    ci.reset_req = 1'b1;
    @(negedge clk);
    ci.reset_req = 1'b0;
    repeat (ADD_LAT + 6) @(negedge clk);
    check("rreq_done", 32'(ci.done), 32'd0);
    check("rreq_result_kept", ci.result, 32'h3F80_0000);
    run(OP_ACC_RD, 0, 32'h0, 32'h0, 32'h3F80_0000, 1);
    // reset_req wins over a simultaneous start
    ci.reset_req = 1'b1; ci.start = 1'b1; ci.n = {2'd0, OP_ACC_CLR};
    @(negedge clk);
    ci.reset_req = 1'b0; ci.start = 1'b0;
    @(negedge clk);
    check("rreq_start_done", 32'(ci.done), 32'd0);
    run(OP_ACC_RD, 0, 32'h0, 32'h0, 32'h3F80_0000, 1);

    // Mixed random traffic against the accumulator model
    for (int i = 0; i < NUM_ACC; i++) begin
      acc_m[i] = r2f(real'(i + 1));
      run(OP_ACC_LD, i, acc_m[i], 32'h0, acc_m[i], 1);
    end
    for (int k = 0; k < 24; k++) begin
      op  = 3'($urandom_range(6));
      if (op == OP_ACC_CLR) op = OP_MAC;
      idx = int'($urandom_range(NUM_ACC - 1));
      a   = rnd_fp();
      b   = rnd_fp();
      case (op)
        OP_ADD: res = r2f(f2r(a) + f2r(b));
        OP_SUB: res = r2f(f2r(a) - f2r(b));
        OP_MUL: res = r2f(f2r(a) * f2r(b));
        OP_MAC: begin
          p = r2f(f2r(a) * f2r(b));
          res = r2f(f2r(p) + f2r(acc_m[idx]));
          acc_m[idx] = res;
        end
        OP_ACC_RD: res = acc_m[idx];
        default: begin
          res = a;
          acc_m[idx] = a;
        end
      endcase
      run(op, idx, a, b, res, lat_of(op));
    end

    // Asynchronous reset mid-SUB clears outputs immediately and all accumulators
    issue(OP_SUB, 0, 32'h4040_0000, 32'h3F80_0000, 32'h0, 0, 0, 1'b0);
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("arst_done", 32'(ci.done), 32'd0);
    check("arst_result", ci.result, 32'h0);
    check("arst_add_a", add_a, 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NUM_ACC; i++) run(OP_ACC_RD, i, 32'h0, 32'h0, 32'h0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
